// File: rtl/branch_resolve.sv
// Branch resolution stage.
// Turns the ALU comparison flags into a registered branch decision (taken,
// target, redirect PC, mispredict) behind a one-deep valid/ready output
// register, and keeps saturating counts of retired taken branches and
// mispredicts.
module branch_resolve #(
  parameter int WORDSIZE = 64,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          funct3,
  input  logic                less,
  input  logic                less_u,
  input  logic                zero,
  input  logic [WORDSIZE-1:0] pc,
  input  logic [WORDSIZE-1:0] imm,
  input  logic                pred_taken,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                taken,
  output logic [WORDSIZE-1:0] target,
  output logic [WORDSIZE-1:0] redirect_pc,
  output logic                mispredict,
  output logic                illegal,
  output logic                misaligned,
  output logic [CNT_W-1:0]    taken_cnt,
  output logic [CNT_W-1:0]    mispred_cnt
);

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Next-state values of the result register, computed from the inputs.
  logic                cond_true;
  logic                is_illegal;
  logic                taken_d;
  logic                misaligned_d;
  logic                mispredict_d;
  logic [WORDSIZE-1:0] target_d;
  logic [WORDSIZE-1:0] seq_pc_d;
  logic [WORDSIZE-1:0] redirect_d;

  // Handshake qualifiers.
  logic capture;
  logic accept;

  // Decode funct3 into the branch condition; the two unused encodings are
  // flagged illegal and never count as taken.
  always_comb begin
    cond_true  = 1'b0;
    is_illegal = 1'b0;
    unique case (funct3)
      F3_BEQ:  cond_true = zero;
      F3_BNE:  cond_true = ~zero;
      F3_BLT:  cond_true = less;
      F3_BGE:  cond_true = ~less;
      F3_BLTU: cond_true = less_u;
      F3_BGEU: cond_true = ~less_u;
      default: is_illegal = 1'b1;
    endcase
  end

  // Both sums wrap modulo 2^WORDSIZE; carry-out is intentionally dropped.
  assign target_d = pc + imm;
  assign seq_pc_d = pc + WORDSIZE'(4);

  assign taken_d      = cond_true & ~is_illegal;
  assign misaligned_d = taken_d & (target_d[1:0] != 2'b00);

  // A misaligned target still redirects to the target so the trap unit sees
  // the faulting address; fetch must not treat it as a mispredict.
  assign redirect_d   = taken_d ? target_d : seq_pc_d;
  assign mispredict_d = ~is_illegal & ~misaligned_d & (taken_d ^ pred_taken);

  // The stage can take a new branch whenever the held result is empty or is
  // leaving this cycle.
  assign in_ready = ~out_valid | out_ready;
  assign capture  = in_valid & in_ready & ~flush;
  assign accept   = out_valid & out_ready & ~flush;

  // Valid flag: flush empties the stage, capture fills it, accept drains it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

  // Result register: loads only on capture so the outputs hold under
  // backpressure and keep their last value when the stage is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      taken       <= 1'b0;
      target      <= '0;
      redirect_pc <= '0;
      mispredict  <= 1'b0;
      illegal     <= 1'b0;
      misaligned  <= 1'b0;
    end else if (capture) begin
      taken       <= taken_d;
      target      <= target_d;
      redirect_pc <= redirect_d;
      mispredict  <= mispredict_d;
      illegal     <= is_illegal;
      misaligned  <= misaligned_d;
    end
  end

  // Taken counter: counts the outgoing result on accept, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt <= '0;
    end else if (accept && taken && (taken_cnt != CNT_MAX)) begin
      taken_cnt <= taken_cnt + CNT_ONE;
    end
  end

  // Mispredict counter: same accept qualification and saturation as above.
  always_ff @(posedge clk) begin
    if (reset) begin
      mispred_cnt <= '0;
    end else if (accept && mispredict && (mispred_cnt != CNT_MAX)) begin
      mispred_cnt <= mispred_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-stage consumer of the ALU comparison flags (less, less-unsigned, zero).
- Each cycle, combines the flags with the branch funct3, PC and immediate into a registered branch decision: taken, target, redirect PC, mispredict.
- Sits between the flag comparators and the fetch/PC-select logic.
- One output register stage with valid/ready handshake, flush, and saturating statistics counters.

Parameters:
- WORDSIZE, 64, datapath width of PC, immediate and target.
- CNT_W, 32, width of the taken and mispredict statistics counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard the held result and any input presented this cycle.
- in_valid  input  1  upstream presents a branch.
- in_ready  output  1  stage can accept this cycle.
- funct3  input  3  RISC-V branch funct3.
- less  input  1  signed rs1<rs2 flag.
- less_u  input  1  unsigned rs1<rs2 flag.
- zero  input  1  rs1==rs2 flag.
- pc  input  WORDSIZE  branch instruction address.
- imm  input  WORDSIZE  sign-extended B-immediate.
- pred_taken  input  1  fetch prediction for this branch.
- out_valid  output  1  result register holds a valid decision.
- out_ready  input  1  downstream accepts the result.
- taken  output  1  branch condition true.
- target  output  WORDSIZE  pc+imm.
- redirect_pc  output  WORDSIZE  taken ? target : pc+4.
- mispredict  output  1  taken != pred_taken, gated by legal and aligned.
- illegal  output  1  funct3 is 010 or 011.
- misaligned  output  1  taken and target[1:0] != 0.
- taken_cnt  output  CNT_W  accepted taken branches, saturating.
- mispred_cnt  output  CNT_W  accepted mispredicts, saturating.

Behaviour:
- Reset: all outputs and registers are 0 the cycle after reset is sampled high. This includes out_valid, taken, target, redirect_pc, mispredict, illegal, misaligned and both counters. Reset overrides flush and all handshakes.
- Ready: in_ready = !out_valid || out_ready (combinational, no dependency on in_valid).
- Capture: on in_valid && in_ready && !flush, the result register loads and out_valid = 1 next cycle. Latency is 1 cycle.
- Hold: when out_valid && !out_ready, all result outputs are held stable.
- Empty: when out_valid && out_ready with no new capture, out_valid goes to 0 next cycle.
- Back-to-back: capture while out_ready = 1 replaces the result in the same edge; full throughput.
- Flush: out_valid = 0 next cycle and the input presented this cycle is dropped. Counters are not updated for the discarded result.
- Condition decode:
  - 000 BEQ: zero
  - 001 BNE: !zero
  - 100 BLT: less
  - 101 BGE: !less
  - 110 BLTU: less_u
  - 111 BGEU: !less_u
  - 010/011: illegal = 1, taken = 0, mispredict = 0, redirect_pc = pc+4
- Arithmetic: target and pc+4 are computed modulo 2^WORDSIZE; wrap-around is silent.
- Misaligned: misaligned = taken && target[1:0] != 0. On a misaligned result, mispredict = 0; redirect_pc still equals target (the trap unit consumes it).
- Counters update only on the accepting edge (out_valid && out_ready && !flush) for the held result:
  - taken_cnt increments if taken.
  - mispred_cnt increments if mispredict.
  - Both saturate at all-ones and never wrap.
- Simultaneous accept and capture: the counter update uses the outgoing result; the register loads the incoming one.
- Reset mid-operation: the held result is lost and counters are cleared.

Test Plan:
- BEQ, zero = 1, pc = 0x1000, imm = 0x20, pred_taken = 0, out_ready = 1 -> next cycle out_valid = 1, taken = 1, target = redirect_pc = 0x1020, mispredict = 1, mispred_cnt = 1 after accept.
- BLT vs BLTU, less = 0, less_u = 1, pc = 0x2000, imm = 0xFFFF_FFFF_FFFF_FFF0 -> BLT: taken = 0, redirect_pc = 0x2004. BLTU: taken = 1, target = 0x1FF0.
- Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, outputs stable, counters unchanged. Then out_ready = 1 -> one accept, next input captured on the same edge.
- funct3 = 010 -> illegal = 1, taken = 0, mispredict = 0. Separately, pc = 0xFFFF_FFFF_FFFF_FFFC with BNE not taken -> redirect_pc = 0x0. Separately, taken with imm = 0x2 -> misaligned = 1, mispredict = 0.
- Flush while out_valid = 1 and in_valid = 1 -> out_valid = 0 next cycle, no counter change. Reset asserted mid-stream -> all outputs 0 the next cycle.
- Saturation, CNT_W = 4: 17 accepted taken mispredicts -> taken_cnt = mispred_cnt = 0xF.
